// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared types for the parametrised traffic light controller
//
// Purpose: state encoding (3-bit codes, also exposed on the debug phase port),
// the lamp bundle struct and the Moore lamp decode shared by the top module.
// Ports: none (package).

package tlc_pkg;

  typedef enum logic [2:0] {
    ST_MAIN_G   = 3'd0,
    ST_MAIN_Y   = 3'd1,
    ST_ALLR_M2S = 3'd2,
    ST_SIDE_G   = 3'd3,
    ST_SIDE_Y   = 3'd4,
    ST_ALLR_S2M = 3'd5,
    ST_FLASH    = 3'd6
  } tlc_state_e;

  typedef struct packed {
    logic mr;
    logic my;
    logic mg;
    logic sr;
    logic sy;
    logic sg;
  } tlc_lamps_t;

  localparam tlc_lamps_t LAMPS_OFF = '0;

  // Lamps depend on the registered state only; blink is used in FLASH alone.
  function automatic tlc_lamps_t decode_lamps(input tlc_state_e st, input logic blink);
    tlc_lamps_t l;
    l = LAMPS_OFF;
    case (st)
      ST_MAIN_G:   begin l.mg = 1'b1; l.sr = 1'b1; end
      ST_MAIN_Y:   begin l.my = 1'b1; l.sr = 1'b1; end
      ST_ALLR_M2S,
      ST_ALLR_S2M: begin l.mr = 1'b1; l.sr = 1'b1; end
      ST_SIDE_G:   begin l.sg = 1'b1; l.mr = 1'b1; end
      ST_SIDE_Y:   begin l.sy = 1'b1; l.mr = 1'b1; end
      ST_FLASH:    begin l.my = blink; l.sr = blink; end
      default:     l = LAMPS_OFF;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - per-phase cycle counter with duration compare
//
// Purpose: counts cycles spent in the current phase. Cleared on phase entry,
// optionally saturating at all-ones, and flags the last cycle of a phase.
// Ports:
//   clk, sync_reset : clock, synchronous active-high reset
//   clr             : next edge starts a new phase (count restarts at 0)
//   sat_en          : hold at all-ones instead of wrapping
//   dur             : duration of the current phase in cycles
//   cnt             : cycles already spent in the phase
//   done            : this is the last cycle of the phase (cnt == dur-1)

module tlc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             clr,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr) begin
      cnt_d = '0;
    end else if (sat_en && (&cnt_q)) begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == (dur - CNT_W'(1)));

endmodule

// File: rtl/tlc_param_controller.sv
// rtl/tlc_param_controller.sv - demand-actuated two-road traffic light controller
//
// Purpose: six-phase main/side cycle with configurable phase lengths, all-red
// clearance, resting main green, pedestrian walk and night flash mode.
// Ports:
//   clk, sync_reset    : clock, synchronous active-high reset
//   side_sense         : side-road vehicle detector (level)
//   ped_req            : pedestrian push button
//   flash_en           : night flash mode request (level)
//   MR/MY/MG, SR/SY/SG : main and side lamps
//   walk               : pedestrian walk across the main road
//   phase              : current state code (debug)

module tlc_param_controller
  import tlc_pkg::*;
#(
  parameter int MAIN_G_MIN = 8,
  parameter int MAIN_Y     = 3,
  parameter int SIDE_G     = 6,
  parameter int SIDE_Y     = 3,
  parameter int ALLRED     = 2,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic       side_sense,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       SR,
  output logic       SY,
  output logic       SG,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int CNT_LIMIT = 2 ** CNT_W;

  if ((MAIN_G_MIN >= CNT_LIMIT) || (MAIN_Y >= CNT_LIMIT) || (SIDE_G >= CNT_LIMIT) ||
      (SIDE_Y >= CNT_LIMIT) || (ALLRED >= CNT_LIMIT) || (FLASH_HALF >= CNT_LIMIT) ||
      (MAIN_Y < 1) || (SIDE_G < 1) || (SIDE_Y < 1) || (FLASH_HALF < 1) ||
      (ALLRED < 0) || (MAIN_G_MIN < 0)) begin : g_bad_params
    $error("tlc_param_controller: duration parameter out of range for CNT_W");
  end

  localparam bit               NO_CLEAR = (ALLRED == 0);
  // MAIN_G_MIN == 0 means a demand is served from the first main-green cycle.
  localparam int               GMIN_M1  = (MAIN_G_MIN > 0) ? (MAIN_G_MIN - 1) : 0;
  localparam logic [CNT_W-1:0] GMIN_CMP = CNT_W'(GMIN_M1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(FLASH_HALF - 1);

  tlc_state_e       state_q, state_d;
  logic             demand_q, demand_d;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_q, walk_d;
  logic             blink_q, blink_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dur;
  logic             done;
  logic             sat_en;
  logic             req_now;
  logic             enter_side;
  tlc_lamps_t       lamps;

  assign req_now = side_sense | ped_req;
  assign sat_en  = (state_q == ST_MAIN_G) || (state_q == ST_FLASH);

  always_comb begin
    dur = '0;
    case (state_q)
      ST_MAIN_Y:   dur = CNT_W'(MAIN_Y);
      ST_ALLR_M2S: dur = CNT_W'(ALLRED);
      ST_SIDE_G:   dur = CNT_W'(SIDE_G);
      ST_SIDE_Y:   dur = CNT_W'(SIDE_Y);
      ST_ALLR_S2M: dur = CNT_W'(ALLRED);
      default:     dur = '0;
    endcase
  end

  tlc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .sync_reset(sync_reset),
    .clr       (state_d != state_q),
    .sat_en    (sat_en),
    .dur       (dur),
    .cnt       (cnt),
    .done      (done)
  );

  // Next-state logic. Flash requests are only honoured at the end of the side
  // clearance so the lamps never jump straight from a green into blinking.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MAIN_G: begin
        if ((cnt >= GMIN_CMP) && (demand_q || req_now)) begin
          state_d = ST_MAIN_Y;
        end
      end
      ST_MAIN_Y: begin
        if (done) begin
          state_d = NO_CLEAR ? ST_SIDE_G : ST_ALLR_M2S;
        end
      end
      ST_ALLR_M2S: begin
        if (done) begin
          state_d = ST_SIDE_G;
        end
      end
      ST_SIDE_G: begin
        if (done) begin
          state_d = ST_SIDE_Y;
        end
      end
      ST_SIDE_Y: begin
        if (done) begin
          if (NO_CLEAR) begin
            state_d = flash_en ? ST_FLASH : ST_MAIN_G;
          end else begin
            state_d = ST_ALLR_S2M;
          end
        end
      end
      ST_ALLR_S2M: begin
        if (done) begin
          state_d = flash_en ? ST_FLASH : ST_MAIN_G;
        end
      end
      ST_FLASH: begin
        // Leaving flash passes through red-red before main green.
        if (!flash_en) begin
          state_d = NO_CLEAR ? ST_MAIN_G : ST_ALLR_S2M;
        end
      end
      default: state_d = ST_MAIN_G;
    endcase
  end

  assign enter_side = (state_d == ST_SIDE_G) && (state_q != ST_SIDE_G);

  // Latches clear on side-green entry, but a request in that same cycle is
  // OR-ed back in so it is not lost and gets served on the next cycle.
  always_comb begin
    demand_d   = (enter_side ? 1'b0 : demand_q) | req_now;
    ped_pend_d = (enter_side ? 1'b0 : ped_pend_q) | ped_req;
    walk_d     = 1'b0;
    if (enter_side) begin
      walk_d = ped_pend_q;
    end else if (state_d == ST_SIDE_G) begin
      walk_d = walk_q;
    end
  end

  // Blink starts lit on flash entry and toggles every FLASH_HALF cycles.
  always_comb begin
    blink_d = 1'b0;
    bcnt_d  = '0;
    if (state_d == ST_FLASH) begin
      if (state_q != ST_FLASH) begin
        blink_d = 1'b1;
      end else if (bcnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q    <= ST_MAIN_G;
      demand_q   <= 1'b0;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      blink_q    <= 1'b0;
      bcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      demand_q   <= demand_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      blink_q    <= blink_d;
      bcnt_q     <= bcnt_d;
    end
  end

  assign lamps = decode_lamps(state_q, blink_q);
  assign MR    = lamps.mr;
  assign MY    = lamps.my;
  assign MG    = lamps.mg;
  assign SR    = lamps.sr;
  assign SY    = lamps.sy;
  assign SG    = lamps.sg;
  assign walk  = walk_q;
  assign phase = state_q;

  a_no_conflict: assert property (@(posedge clk)
    !((lamps.mg | lamps.my) && (lamps.sg | lamps.sy)));

  a_one_lamp_each: assert property (@(posedge clk)
    (state_q == ST_FLASH) ||
    ($onehot({lamps.mr, lamps.my, lamps.mg}) && $onehot({lamps.sr, lamps.sy, lamps.sg})));

endmodule
